// File: rtl/mem_map_pkg.sv
// Memory-map constants shared by the core memory controller and the bus responder.
package mem_map_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_HALT = 18'h30004;

  localparam logic [1:0] REGION_IO       = 2'b11;
  localparam logic [1:0] REGION_UNMAPPED = 2'b10;

  function automatic logic is_ram_region(input logic [1:0] region);
    return (region != REGION_IO) && (region != REGION_UNMAPPED);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrapping pointers; a pop in the same cycle makes room for a push at full.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic        i_pop,
  output logic [7:0]  o_data,
  output logic [AW:0] o_count,
  output logic [AW:0] o_next_count,
  output logic        o_full,
  output logic        o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign w_pop        = i_pop & ~o_empty;
  assign w_push       = i_push & (~o_full | w_pop);
  assign o_next_count = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign o_count      = r_count;
  assign o_data       = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= o_next_count;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory bus responder: RAM, IO window decode, UART TX buffering, sticky status flags.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_AW      = 17,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        sim_done,
  output logic        tx_overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        r_ram [2**RAM_AW];
  logic [7:0]        r_mem_din;
  logic              r_io_buffer_full;
  logic              r_sim_done;
  logic              r_tx_overflow;

  logic              w_is_ram;
  logic              w_is_io;
  logic              w_uart_wr;
  logic              w_halt_wr;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_next_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_unused_addr;

  assign w_unused_addr = ^{mem_a[31:18], w_count};
  assign w_is_ram      = is_ram_region(mem_a[17:16]);
  assign w_is_io       = (mem_a[17:16] == REGION_IO);
  assign w_ram_addr    = mem_a[RAM_AW-1:0];
  assign w_uart_wr     = mem_wr & w_is_io & (mem_a[17:0] == IO_UART);
  assign w_halt_wr     = mem_wr & w_is_io & (mem_a[17:0] == IO_HALT);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_uart_wr),
    .i_data       (mem_dout),
    .i_pop        (uart_tx_ready),
    .o_data       (uart_tx_data),
    .o_count      (w_count),
    .o_next_count (w_next_count),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty)
  );

  // RAM contents deliberately survive reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr && w_is_ram) r_ram[w_ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_din        <= '0;
      r_io_buffer_full <= 1'b0;
      r_sim_done       <= 1'b0;
      r_tx_overflow    <= 1'b0;
    end else begin
      if (!mem_wr) r_mem_din <= w_is_ram ? r_ram[w_ram_addr] : 8'h00;
      r_io_buffer_full <= (w_next_count >= CW'(FIFO_DEPTH - FULL_MARGIN));
      if (w_halt_wr) r_sim_done <= 1'b1;
      // A full FIFO only rejects the push when no pop frees a slot this cycle.
      if (w_uart_wr && w_fifo_full && !uart_tx_ready) r_tx_overflow <= 1'b1;
    end
  end

  assign mem_din        = r_mem_din;
  assign io_buffer_full = r_io_buffer_full;
  assign uart_tx_valid  = ~w_fifo_empty;
  assign sim_done       = r_sim_done;
  assign tx_overflow    = r_tx_overflow;

endmodule

// File: doc/mem_responder.md
# mem_responder

Responder end of the CPU's byte-wide memory bus: it answers the core memory controller's `mem_a`/`mem_wr`/`mem_dout` requests with RAM data on `mem_din`, decodes the IO window, and buffers UART output bytes. It drives `io_buffer_full` back to the controller. It sits between the CPU top level and the board/testbench UART sink. RAM contents survive `rst`; all control state does not.

## Interface

Parameters:

- `RAM_AW`, 17: RAM address width in bytes. Default is 128 KiB, covering 0x00000–0x1FFFF.
- `FIFO_DEPTH`, 8: UART TX FIFO entries. Must be a power of two, ≥4.
- `FULL_MARGIN`, 2: free-entry headroom at which `io_buffer_full` asserts.

Ports (clock and reset first):

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_a` in 32: byte address from the controller. Only [17:0] are decoded.
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_dout` in 8: write data from the controller.
- `mem_din` out 8: read data to the controller, registered.
- `io_buffer_full` out 1: UART FIFO near full, registered.
- `uart_tx_valid` out 1: head byte available.
- `uart_tx_data` out 8: head byte.
- `uart_tx_ready` in 1: sink accepts the byte this cycle.
- `sim_done` out 1: sticky; set by a write to `IO_HALT`.
- `tx_overflow` out 1: sticky; a UART write was dropped.

## Operation

Address decode uses `mem_a[17:16]`:

- 2'b00 or 2'b01: RAM at `mem_a[RAM_AW-1:0]`.
- 2'b10: unmapped. Reads return 0x00; writes are ignored.
- 2'b11: IO window. Only `mem_a[17:0]` = 0x30000 (`IO_UART`) and 0x30004 (`IO_HALT`) are defined. Other IO addresses read 0x00 and ignore writes.

RAM:

- Write: when `mem_wr`=1 at a posedge, `mem_dout` is stored at the addressed byte.
- Read: when `mem_wr`=0, `mem_din` is loaded at the posedge with `ram[addr]` (old contents, read-before-write semantics not applicable since `mem_wr`=0).

IO window:

- Read of any IO address loads `mem_din`=0x00.
- Write to `IO_UART` pushes `mem_dout[7:0]` into the FIFO.
- Write to `IO_HALT` sets `sim_done`.

UART FIFO:

- Push while count==`FIFO_DEPTH`: byte dropped, `tx_overflow` set, count unchanged.
- `uart_tx_valid` = (count != 0). `uart_tx_data` = head entry, driven combinationally from FIFO storage.
- Pop happens on `uart_tx_valid && uart_tx_ready`.
- Push and pop in the same cycle: both occur and count is unchanged. This includes count==`FIFO_DEPTH`: the pop frees the slot and the push is accepted.
- Read/write pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth. Count is log2(`FIFO_DEPTH`)+1 bits.
- `io_buffer_full` next = (next_count ≥ `FIFO_DEPTH` − `FULL_MARGIN`).

Reset:

- Values: `mem_din`=0, `io_buffer_full`=0, `sim_done`=0, `tx_overflow`=0, pointers and count = 0, so `uart_tx_valid`=0.
- Reset mid-operation discards queued UART bytes and suppresses any write presented in the same cycle, both RAM and IO.
- RAM array is not cleared.

## Timing

- Read latency is 1 cycle. For an address held in cycle t (sampled at posedge t→t+1), data is valid on `mem_din` after that posedge and holds until the next read.
- A RAM write is visible to a read of the same address issued in the following cycle.
- `io_buffer_full` lags the push by one cycle. `FULL_MARGIN` covers the controller seeing the flag late.
- `sim_done` and `tx_overflow` assert the cycle after the triggering write. They clear only on `rst`.
- First UART byte: `uart_tx_valid` high the cycle after the push.
- Throughput: one pop per cycle while `uart_tx_ready` is held high.

## Structure

- Shared package `mem_map_pkg`:
  - `IO_BASE`=18'h30000, `IO_UART`=18'h30000, `IO_HALT`=18'h30004.
  - Region decode constants: `REGION_IO`=2'b11, `REGION_UNMAPPED`=2'b10.
  - The package is also imported by the core memory controller.
- One sub-module: `byte_fifo`, a parameterised depth FIFO with push/pop/count/full/empty.
- Decode, RAM array and sticky flags stay in `mem_responder`.

## Test plan

- Write 0xA5 to 0x00010 then 0x3C to 0x00011. Read 0x00010 then 0x00011 → `mem_din`=0xA5, then 0x3C, each one cycle after its address.
- Write 0x41, 0x42, 0x43 to 0x30000 with `uart_tx_ready`=1 → `uart_tx_data` sequence 0x41, 0x42, 0x43. Each byte valid one cycle after its push; FIFO empty afterwards.
- Hold `uart_tx_ready`=0 and push 6 bytes (depth 8, margin 2) → `io_buffer_full`=1 the cycle after the 6th push. Push 2 more → count 8, still no overflow. Push a 9th → `tx_overflow`=1 and that byte is never emitted.
- At count=8, push 0x55 while `uart_tx_ready`=1 → oldest byte popped, 0x55 accepted, count stays 8, `tx_overflow` stays 0. Drain order is preserved across pointer wrap.
- Write any value to 0x30004 → `sim_done`=1 next cycle. Read 0x30000 or 0x20000 → `mem_din`=0x00.
- Queue 3 bytes, write 0x77 to 0x00020, then assert `rst` for 1 cycle → `uart_tx_valid`=0, `mem_din`=0, flags cleared. A subsequent read of 0x00020 returns 0x77.
